fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_ADDRESS, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter LINE_WORDS, default 4, the 32-bit words per cache line (power of two, 2..16).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port cache_hit, input, 1 bit: the instruction cache hit for the current instruction_address.
REQ-006 SHALL have port hazard_stall, input, 1 bit: hazard unit requests the PC be held.
REQ-007 SHALL have port branch_taken, input, 1 bit: a taken-branch redirect.
REQ-008 SHALL have port branch_target, input, 32 bits: the branch destination.
REQ-009 SHALL have port jump, input, 1 bit: a jump redirect.
REQ-010 SHALL have port jump_target, input, 32 bits: the jump destination.
REQ-011 SHALL have port memory_ready, input, 1 bit: main memory accepts and returns the current refill word.
REQ-012 SHALL have port memory_read, output, 1 bit: refill word request.
REQ-013 SHALL have port memory_address, output, 32 bits: refill word address.
REQ-014 SHALL have port refill_done, output, 1 bit: one-cycle pulse telling the cache the line is complete.
REQ-015 SHALL have port instruction_address, output, 32 bits: the registered PC.
REQ-016 SHALL have port fetch_valid, output, 1 bit: the instruction at instruction_address is delivered this cycle.

Function
REQ-017 SHALL implement states FETCH, REFILL and DONE, encoded in 2 bits.
REQ-018 In FETCH with hazard_stall=0, SHALL select next PC by priority jump > branch_taken > (PC+4), latched on the next edge.
REQ-019 In FETCH, a redirect (jump or branch_taken) with hazard_stall=0 SHALL load the target even when cache_hit=0, with no miss started.
REQ-020 In FETCH, with no redirect, cache_hit=1 and hazard_stall=0, SHALL advance PC by 4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0) and drive fetch_valid=1.
REQ-021 In FETCH with hazard_stall=1, SHALL hold PC and drive fetch_valid=0; hazard_stall takes precedence over redirects and misses.
REQ-022 In FETCH, with no redirect, cache_hit=0 and hazard_stall=0, SHALL hold PC, latch line_base = PC with low log2(LINE_WORDS*4) bits cleared, clear the word counter, and enter REFILL.
REQ-023 In REFILL, SHALL drive memory_read=1 and memory_address = line_base + 4*counter, holding both stable until memory_ready=1.
REQ-024 In REFILL, on memory_ready=1, SHALL increment the counter; on the accept of word LINE_WORDS-1, SHALL enter DONE.
REQ-025 In DONE, SHALL pulse refill_done=1 for exactly one cycle, hold PC, and return to FETCH.
REQ-026 Outside FETCH, SHALL ignore redirects, cache_hit and hazard_stall, drive fetch_valid=0, and hold PC.
REQ-027 The miss-to-resume penalty with a zero-wait memory SHALL be LINE_WORDS+2 cycles.
REQ-028 memory_read and memory_address SHALL be combinational from state and registers only, never from memory_ready.
REQ-029 The PC SHALL be word aligned; bits [1:0] of targets SHALL be forced to 0.

Reset
REQ-030 reset=0 SHALL immediately set instruction_address=RESET_ADDRESS, state=FETCH, counter=0, memory_read=0, refill_done=0 and fetch_valid=0.
REQ-031 Reset asserted mid-REFILL SHALL abandon the refill with no refill_done pulse.
REQ-032 The first edge after reset release SHALL be evaluated as FETCH.

Structure
REQ-033 The state encoding, the constant WORD_BYTES=4 and RESET_ADDRESS SHALL live in the shared mips_pkg package.
REQ-034 The PC register with its hold enable SHALL be one sub-module, pc_holding_register; the next-PC mux and FSM stay in fetch_controller.

Verification
REQ-035 Reset, then 3 cycles with cache_hit=1 -> instruction_address 0, 4, 8, 12; fetch_valid=1 each cycle.
REQ-036 PC=32'h0000_0014 with cache_hit=0 and memory_ready always 1 -> memory_address 0x10, 0x14, 0x18, 0x1C; one refill_done pulse; PC stays 0x14 until resume.
REQ-037 Same miss with memory_ready=1 only every third cycle -> memory_address held stable between accepts; refill_done after 12 cycles.
REQ-038 jump=1 to 0x400 and branch_taken=1 to 0x200 with cache_hit=0 -> PC=0x400, no memory_read.
REQ-039 hazard_stall=1 with jump=1 -> PC unchanged, fetch_valid=0; jump is then honoured the cycle hazard_stall drops.
REQ-040 reset asserted during the second refill word -> memory_read drops at once, PC=RESET_ADDRESS, no refill_done; PC=32'hFFFF_FFFC on a hit -> wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: fetch-path FSM encoding, word size, reset vector and alignment helper.
package mips_pkg;
  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int WORD_BYTES = 4;
  localparam logic [31:0] RESET_ADDRESS = 32'h0000_0000;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if: cache, hazard, redirect and refill-memory signals of the fetch stage.
interface fetch_controller_if;
  logic cache_hit;
  logic hazard_stall;
  logic branch_taken;
  logic [31:0] branch_target;
  logic jump;
  logic [31:0] jump_target;
  logic memory_ready;
  logic memory_read;
  logic [31:0] memory_address;
  logic refill_done;
  logic [31:0] instruction_address;
  logic fetch_valid;
  modport master(
    input cache_hit, hazard_stall, branch_taken, branch_target, jump, jump_target, memory_ready,
    output memory_read, memory_address, refill_done, instruction_address, fetch_valid
  );
  modport slave(
    output cache_hit, hazard_stall, branch_taken, branch_target, jump, jump_target, memory_ready,
    input memory_read, memory_address, refill_done, instruction_address, fetch_valid
  );
endinterface

// File: rtl/pc_holding_register.sv
// pc_holding_register: program counter that loads i_next when i_load is high, else holds.
module pc_holding_register #(
  parameter logic [31:0] RESET_ADDRESS = mips_pkg::RESET_ADDRESS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_next,
  output logic [31:0] o_pc
);
  logic [31:0] r_pc;
  always_ff @(posedge clock or negedge reset)
    if (!reset) r_pc <= RESET_ADDRESS;
    else if (i_load) r_pc <= i_next;
  assign o_pc = r_pc;
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: next-PC selection plus a FETCH/REFILL/DONE FSM that refills a missed
// cache line one word at a time from main memory.
module fetch_controller #(
  parameter logic [31:0] RESET_ADDRESS = mips_pkg::RESET_ADDRESS,
  parameter int LINE_WORDS = 4
) (
  input logic clock,
  input logic reset,
  fetch_controller_if.master bus
);
  import mips_pkg::*;
  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * WORD_BYTES - 1);
  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic [CW-1:0] r_count;
  logic [31:0] r_line_base;
  logic [31:0] w_pc;
  logic [31:0] w_next_pc;
  logic w_fetch;
  logic w_go;
  logic w_redirect;
  logic w_miss;
  logic w_last;
  assign w_fetch = r_state == S_FETCH;
  assign w_go = w_fetch && !bus.hazard_stall;
  assign w_redirect = bus.jump || bus.branch_taken;
  assign w_miss = w_go && !w_redirect && !bus.cache_hit;
  assign w_last = r_count == CW'(LINE_WORDS - 1);
  assign w_next_pc = bus.jump ? word_align(bus.jump_target)
                   : bus.branch_taken ? word_align(bus.branch_target)
                   : w_pc + 32'd4;
  pc_holding_register #(.RESET_ADDRESS(word_align(RESET_ADDRESS))) u_pc (
    .clock (clock),
    .reset (reset),
    .i_load(w_go && (w_redirect || bus.cache_hit)),
    .i_next(w_next_pc),
    .o_pc  (w_pc)
  );
  always_comb
    w_state_next = w_fetch ? (w_miss ? S_REFILL : S_FETCH)
                 : r_state == S_REFILL ? (bus.memory_ready && w_last ? S_DONE : S_REFILL)
                 : S_FETCH;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
      r_line_base <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_miss) begin
        r_line_base <= w_pc & ~LINE_MASK;
        r_count <= '0;
      end else if (r_state == S_REFILL && bus.memory_ready) begin
        r_count <= r_count + CW'(1);
      end
    end
  // refill request depends only on registered state, never on memory_ready
  assign bus.memory_read = r_state == S_REFILL;
  assign bus.memory_address = r_line_base + (32'(r_count) << 2);
  assign bus.refill_done = r_state == S_DONE;
  assign bus.instruction_address = w_pc;
  assign bus.fetch_valid = reset && w_go && bus.cache_hit;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed scenarios for the fetch controller with hand-computed expectations.
module tb_fetch_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  fetch_controller_if bus();
  fetch_controller #(.RESET_ADDRESS(32'h0000_0000), .LINE_WORDS(4)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.cache_hit = 1'b1;
    bus.hazard_stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = '0;
    bus.jump = 1'b0;
    bus.jump_target = '0;
    bus.memory_ready = 1'b0;
    #12;
    checks++; if (bus.instruction_address !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", bus.instruction_address); end
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got=%b exp=0", bus.fetch_valid); end
    checks++; if (bus.memory_read !== 1'b0) begin errors++; $display("FAIL reset_memory_read got=%b exp=0", bus.memory_read); end
    checks++; if (bus.refill_done !== 1'b0) begin errors++; $display("FAIL reset_refill_done got=%b exp=0", bus.refill_done); end
    reset = 1'b1;
    #1;
  endtask

  task automatic test_sequential();
    checks++; if (bus.instruction_address !== 32'h0) begin errors++; $display("FAIL seq_pc0 got=%h exp=0", bus.instruction_address); end
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_valid0 got=%b exp=1", bus.fetch_valid); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (bus.instruction_address !== 32'(4 * i)) begin errors++; $display("FAIL seq_pc%0d got=%h exp=%h", i, bus.instruction_address, 32'(4 * i)); end
      checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got=%b exp=1", i, bus.fetch_valid); end
    end
  endtask

  task automatic test_refill();
    bus.jump = 1'b1;
    bus.jump_target = 32'h14;
    bus.cache_hit = 1'b0;
    tick();
    bus.jump = 1'b0;
    bus.memory_ready = 1'b1;
    #1;
    checks++; if (bus.instruction_address !== 32'h14) begin errors++; $display("FAIL refill_start_pc got=%h exp=14", bus.instruction_address); end
    checks++; if (bus.memory_read !== 1'b0) begin errors++; $display("FAIL refill_miss_read got=%b exp=0", bus.memory_read); end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.memory_read !== 1'b1) begin errors++; $display("FAIL refill_read%0d got=%b exp=1", i, bus.memory_read); end
      checks++; if (bus.memory_address !== 32'(32'h10 + 4 * i)) begin errors++; $display("FAIL refill_addr%0d got=%h exp=%h", i, bus.memory_address, 32'(32'h10 + 4 * i)); end
      checks++; if (bus.instruction_address !== 32'h14 || bus.refill_done !== 1'b0) begin errors++; $display("FAIL refill_hold%0d pc=%h done=%b exp pc=14 done=0", i, bus.instruction_address, bus.refill_done); end
      tick();
    end
    checks++; if (bus.refill_done !== 1'b1) begin errors++; $display("FAIL refill_done_pulse got=%b exp=1", bus.refill_done); end
    checks++; if (bus.memory_read !== 1'b0 || bus.instruction_address !== 32'h14) begin errors++; $display("FAIL refill_done_state read=%b pc=%h exp read=0 pc=14", bus.memory_read, bus.instruction_address); end
    tick();
    checks++; if (bus.refill_done !== 1'b0) begin errors++; $display("FAIL refill_done_single got=%b exp=0", bus.refill_done); end
    bus.cache_hit = 1'b1;
    #1;
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL refill_resume_valid got=%b exp=1", bus.fetch_valid); end
    tick();
    checks++; if (bus.instruction_address !== 32'h18) begin errors++; $display("FAIL refill_resume_pc got=%h exp=18", bus.instruction_address); end
  endtask

  task automatic test_slow_memory();
    int n = 0;
    int acc = 0;
    bus.jump = 1'b1;
    bus.jump_target = 32'h14;
    bus.cache_hit = 1'b0;
    bus.memory_ready = 1'b0;
    tick();
    bus.jump = 1'b0;
    tick();
    while (bus.memory_read === 1'b1 && n < 40) begin
      bus.memory_ready = (n % 3) == 2;
      #1;
      checks++; if (bus.memory_address !== 32'(32'h10 + 4 * acc)) begin errors++; $display("FAIL slow_addr cycle%0d got=%h exp=%h", n, bus.memory_address, 32'(32'h10 + 4 * acc)); end
      if (bus.memory_ready) acc++;
      n++;
      tick();
    end
    bus.memory_ready = 1'b0;
    checks++; if (n !== 12) begin errors++; $display("FAIL slow_refill_cycles got=%0d exp=12", n); end
    checks++; if (bus.refill_done !== 1'b1) begin errors++; $display("FAIL slow_refill_done got=%b exp=1", bus.refill_done); end
    bus.cache_hit = 1'b1;
    tick();
    tick();
    checks++; if (bus.instruction_address !== 32'h18) begin errors++; $display("FAIL slow_resume_pc got=%h exp=18", bus.instruction_address); end
  endtask

  task automatic test_redirect();
    bus.jump = 1'b1;
    bus.jump_target = 32'h400;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h200;
    bus.cache_hit = 1'b0;
    #1;
    checks++; if (bus.memory_read !== 1'b0 || bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL redirect_comb read=%b valid=%b exp 0 0", bus.memory_read, bus.fetch_valid); end
    tick();
    checks++; if (bus.instruction_address !== 32'h400) begin errors++; $display("FAIL redirect_jump_pc got=%h exp=400", bus.instruction_address); end
    checks++; if (bus.memory_read !== 1'b0) begin errors++; $display("FAIL redirect_no_refill got=%b exp=0", bus.memory_read); end
    bus.jump = 1'b0;
    bus.branch_target = 32'h203;
    tick();
    checks++; if (bus.instruction_address !== 32'h200) begin errors++; $display("FAIL redirect_branch_pc got=%h exp=200", bus.instruction_address); end
    bus.branch_taken = 1'b0;
    bus.cache_hit = 1'b1;
  endtask

  task automatic test_hazard();
    bus.hazard_stall = 1'b1;
    bus.jump = 1'b1;
    bus.jump_target = 32'h800;
    #1;
    checks++; if (bus.fetch_valid !== 1'b0) begin errors++; $display("FAIL hazard_valid got=%b exp=0", bus.fetch_valid); end
    tick();
    checks++; if (bus.instruction_address !== 32'h200) begin errors++; $display("FAIL hazard_hold1 got=%h exp=200", bus.instruction_address); end
    tick();
    checks++; if (bus.instruction_address !== 32'h200 || bus.memory_read !== 1'b0) begin errors++; $display("FAIL hazard_hold2 pc=%h read=%b exp pc=200 read=0", bus.instruction_address, bus.memory_read); end
    bus.hazard_stall = 1'b0;
    #1;
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL hazard_release_valid got=%b exp=1", bus.fetch_valid); end
    tick();
    checks++; if (bus.instruction_address !== 32'h800) begin errors++; $display("FAIL hazard_jump_pc got=%h exp=800", bus.instruction_address); end
    bus.jump = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    bus.jump = 1'b1;
    bus.jump_target = 32'h40;
    bus.cache_hit = 1'b0;
    tick();
    bus.jump = 1'b0;
    bus.memory_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.memory_read !== 1'b1 || bus.memory_address !== 32'h44) begin errors++; $display("FAIL midreset_word1 read=%b addr=%h exp read=1 addr=44", bus.memory_read, bus.memory_address); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.memory_read !== 1'b0) begin errors++; $display("FAIL midreset_read got=%b exp=0", bus.memory_read); end
    checks++; if (bus.instruction_address !== 32'h0) begin errors++; $display("FAIL midreset_pc got=%h exp=0", bus.instruction_address); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus.refill_done !== 1'b0) begin errors++; $display("FAIL midreset_done%0d got=%b exp=0", i, bus.refill_done); end
    end
    reset = 1'b1;
    bus.cache_hit = 1'b1;
    bus.memory_ready = 1'b0;
    #1;
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL midreset_resume_valid got=%b exp=1", bus.fetch_valid); end
    tick();
    checks++; if (bus.instruction_address !== 32'h4) begin errors++; $display("FAIL midreset_resume_pc got=%h exp=4", bus.instruction_address); end
  endtask

  task automatic test_wrap();
    bus.jump = 1'b1;
    bus.jump_target = 32'hFFFF_FFFC;
    bus.cache_hit = 1'b0;
    tick();
    checks++; if (bus.instruction_address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got=%h exp=fffffffc", bus.instruction_address); end
    bus.jump = 1'b0;
    bus.cache_hit = 1'b1;
    tick();
    checks++; if (bus.instruction_address !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=0", bus.instruction_address); end
    checks++; if (bus.fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got=%b exp=1", bus.fetch_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_refill();
    test_slow_memory();
    test_redirect();
    test_hazard();
    test_reset_mid_refill();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
